// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN    = 1'b0,
        STALL2 = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection between the ID instruction and the EX instruction.
// Register 0 is hard-wired to zero, so it never forms a dependency.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_uses_rt,
    input  logic              ID_branch,
    input  logic [REG_AW-1:0] EX_dest,
    input  logic              EX_reg_write,
    input  logic              EX_mem_read,
    output logic              loadHz,
    output logic              aluBrHz
);

    logic regMatch;

    // Dependency check and hazard classification
    always_comb begin
        regMatch = (EX_dest != REG_ZERO) &&
                   ((EX_dest == ID_Rs) || (ID_uses_rt && (EX_dest == ID_Rt)));
        loadHz   = EX_mem_read & regMatch;
        aluBrHz  = ID_branch & EX_reg_write & ~EX_mem_read & regMatch;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stalls the front end on load-use and ALU-to-branch
// dependencies, flushes IF/ID on taken branches and jumps.
// A load feeding a branch needs two stall cycles (RUN then STALL2).
// Optional macro HAZARD_STATS_EN enables the stall/flush cycle counters;
// without it the counter ports read as zero.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_uses_rt,
    input  logic              ID_branch,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic [REG_AW-1:0] EX_dest,
    input  logic              EX_reg_write,
    input  logic              EX_mem_read,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    hazard_state_t state;
    logic          loadHz;
    logic          aluBrHz;
    logic          stallNow;

    hazard_detect uDetect (
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_uses_rt   (ID_uses_rt),
        .ID_branch    (ID_branch),
        .EX_dest      (EX_dest),
        .EX_reg_write (EX_reg_write),
        .EX_mem_read  (EX_mem_read),
        .loadHz       (loadHz),
        .aluBrHz      (aluBrHz)
    );

    // STALL2 stalls regardless of inputs; in RUN any hazard stalls immediately
    assign stallNow = (state == STALL2) | loadHz | aluBrHz;

    // State register: a load feeding a branch holds the front end one extra cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= (loadHz & ID_branch) ? STALL2 : RUN;
                STALL2:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Output decode: reset, then stall, then redirect, then normal flow
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stallNow) begin
            // Stall beats a simultaneous redirect; the branch is re-evaluated afterwards
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (branch_taken | jump) begin
            ifid_flush  = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    // Cycle counters for stalls and flushes, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stallNow)   stall_count <= stall_count + 32'd1;
            if (ifid_flush) flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, compared against a behavioural reference model that
// tracks the number of stall cycles still owed.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_dest;
    logic        ID_uses_rt, ID_branch, branch_taken, jump;
    logic        EX_reg_write, EX_mem_read;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [31:0] stall_count, flush_count;

    int          nCmp  = 0;
    int          nFail = 0;

    // Reference model state
    int          owed;       // stall cycles still owed after the current one
    logic [31:0] mStall, mFlush;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_uses_rt   (ID_uses_rt),
        .ID_branch    (ID_branch),
        .branch_taken (branch_taken),
        .jump         (jump),
        .EX_dest      (EX_dest),
        .EX_reg_write (EX_reg_write),
        .EX_mem_read  (EX_mem_read),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit depLoad();
        bit dep;
        dep = (EX_dest != 5'd0) && (EX_dest == ID_Rs || (ID_uses_rt && EX_dest == ID_Rt));
        return EX_mem_read && dep;
    endfunction

    function automatic bit depAluBr();
        bit dep;
        dep = (EX_dest != 5'd0) && (EX_dest == ID_Rs || (ID_uses_rt && EX_dest == ID_Rt));
        return ID_branch && EX_reg_write && !EX_mem_read && dep;
    endfunction

    // Expected outputs as {pc_write, ifid_write, ifid_flush, idex_bubble}
    function automatic logic [3:0] expOut();
        if (rst)                                  return 4'b0011;
        if (owed > 0 || depLoad() || depAluBr())  return 4'b0001;
        if (branch_taken || jump)                 return 4'b1110;
        return 4'b1100;
    endfunction

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge
    task automatic runCycle(input string tag);
        logic [3:0] e;
        @(negedge clk);
        e = expOut();
        chk({tag, ".pc_write"},    32'(pc_write),    32'(e[3]));
        chk({tag, ".ifid_write"},  32'(ifid_write),  32'(e[2]));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e[1]));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e[0]));
        chk({tag, ".stall_count"}, stall_count, mStall);
        chk({tag, ".flush_count"}, flush_count, mFlush);
        @(posedge clk);
        if (rst) begin
            owed   = 0;
            mStall = '0;
            mFlush = '0;
        end else begin
`ifdef HAZARD_STATS_EN
            if (e == 4'b0001) mStall = mStall + 32'd1;
            if (e[1])         mFlush = mFlush + 32'd1;
`endif
            if (owed > 0)                    owed = owed - 1;
            else if (depLoad() && ID_branch) owed = 1;
        end
        #1;
    endtask

    task automatic clearIn();
        rst = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_uses_rt = 1'b0; ID_branch = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; EX_dest = '0; EX_reg_write = 1'b0; EX_mem_read = 1'b0;
    endtask

    task automatic doReset();
        clearIn();
        rst = 1'b1;
        runCycle("reset");
        rst = 1'b0;
    endtask

    initial begin
        owed = 0; mStall = '0; mFlush = '0;
        clearIn();
        rst = 1'b1;
        @(posedge clk); #1;
        runCycle("reset_hold");
        rst = 1'b0;
        runCycle("idle");

        // Load-use: one stall, then normal flow
        doReset();
        EX_dest = 5'd8; EX_mem_read = 1'b1; EX_reg_write = 1'b1; ID_Rs = 5'd8;
        runCycle("loaduse_stall");
        EX_dest = 5'd0; EX_mem_read = 1'b0; EX_reg_write = 1'b0;
        runCycle("loaduse_after");
        runCycle("loaduse_cnt");

        // Load feeding a branch: two stalls, second one independent of inputs
        doReset();
        EX_dest = 5'd9; EX_mem_read = 1'b1; EX_reg_write = 1'b1;
        ID_Rt = 5'd9; ID_uses_rt = 1'b1; ID_branch = 1'b1;
        runCycle("ldbr_stall1");
        EX_dest = 5'd0; EX_mem_read = 1'b0; EX_reg_write = 1'b0;
        runCycle("ldbr_stall2");
        runCycle("ldbr_run");
        runCycle("ldbr_cnt");

        // ALU result feeding a branch: one stall; destination r0 never stalls
        doReset();
        EX_dest = 5'd10; EX_reg_write = 1'b1; ID_Rs = 5'd10; ID_branch = 1'b1;
        runCycle("alubr_stall");
        EX_dest = 5'd0;
        runCycle("alubr_r0");
        ID_Rs = 5'd0; EX_mem_read = 1'b1;
        runCycle("load_r0");

        // Jump redirect flushes IF/ID
        doReset();
        jump = 1'b1;
        runCycle("jump_flush");
        jump = 1'b0;
        runCycle("jump_cnt");

        // Stall wins over a taken branch, redirect follows one cycle later
        doReset();
        EX_dest = 5'd7; EX_mem_read = 1'b1; ID_Rs = 5'd7; branch_taken = 1'b1;
        runCycle("prio_stall");
        EX_dest = 5'd0; EX_mem_read = 1'b0;
        runCycle("prio_flush");
        branch_taken = 1'b0;
        runCycle("prio_cnt");

        // Reset while in STALL2 aborts the stall and clears the counters
        doReset();
        runCycle("pre_cnt");
        EX_dest = 5'd3; EX_mem_read = 1'b1; ID_Rs = 5'd3; ID_branch = 1'b1;
        runCycle("rs2_stall1");
        clearIn();
        rst = 1'b1;
        runCycle("rs2_reset");
        rst = 1'b0;
        ID_Rs = 5'd3; ID_branch = 1'b1;
        runCycle("rs2_run");
        runCycle("rs2_cnt");

        // Randomized traffic with small register indices to provoke collisions
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            ID_Rs        = 5'($urandom_range(0, 3));
            ID_Rt        = 5'($urandom_range(0, 3));
            ID_uses_rt   = 1'($urandom_range(0, 1));
            ID_branch    = 1'($urandom_range(0, 1));
            branch_taken = ID_branch & 1'($urandom_range(0, 1));
            jump         = ($urandom_range(0, 7) == 0);
            EX_dest      = 5'($urandom_range(0, 3));
            EX_reg_write = 1'($urandom_range(0, 1));
            EX_mem_read  = ($urandom_range(0, 3) == 0);
            runCycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
